inst_fetch: RTL and testbench

- Fetch front end that sits between the program-counter logic and instruction memory.
- Owns the fetch PC and issues word-aligned read requests to imem over a req/gnt handshake.
- Collects in-order read responses into a small buffer and presents {pc, instr} to decode over a valid/ready handshake.
- Redirect input (branch/jump/trap) reloads the PC, flushes buffered instructions and discards responses still in flight.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/inst_fetch.sv | 92 +++++++++
 tb/tb_inst_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and helpers for the fetch front end.
package cpu_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0013;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; entries are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= push_data;
    end

    assign pop_data = mem[head];
endmodule

// File: rtl/inst_fetch.sv
// Fetch front end: owns the PC, issues imem reads under a credit limit and buffers
// in-order responses for decode; redirect reloads the PC and drops in-flight reads.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + INSTR_W;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   drop;
    logic [XLEN-1:0] tag;
    logic [EW-1:0]   head_entry;
    logic [CW:0]     in_use;
    logic            pop;
    logic            grant;
    logic            resp;
    logic            resp_keep;

    // A same-cycle pop frees a slot, which is what lets DEPTH=2 stream 1 instr/cycle.
    assign pop       = if_valid & if_ready & ~redirect_valid;
    assign in_use    = {1'b0, outstanding} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
    assign imem_req  = rst & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp      = imem_rvalid & (outstanding != '0);
    assign resp_keep = resp & (drop == '0) & ~redirect_valid;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (grant),
        .push_data (fetch_pc),
        .pop       (resp),
        .pop_data  (tag),
        .count     (outstanding)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data ({tag, imem_rdata}),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (buf_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this edge is stale.
            fetch_pc <= word_align(redirect_pc);
            drop     <= outstanding + CW'(grant) - CW'(resp);
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (resp && drop != '0) drop <= drop - 1'b1;
        end
    end

    assign if_valid = (buf_count != '0);
    assign if_pc    = if_valid ? head_entry[EW-1:INSTR_W] : '0;
    assign if_instr = if_valid ? head_entry[INSTR_W-1:0]  : '0;

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst) imem_rvalid |-> (outstanding != '0)
    );
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: imem model with configurable latency, scoreboard on decode side.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_pop = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    int          lat = 1;
    bit          gnt_en = 1'b1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          grant_cnt = 0;
    int          g10 = 0;
    int          g0;

    inst_fetch #(.RESET_PC(RESET_PC_DEFAULT), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0000} | NOP;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_pops(input int target, input int budget);
        int i = 0;
        while (n_pop < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        tests++;
        if (n_pop < target) begin
            fails++;
            $display("FAIL pop_timeout: got %0d pops, want %0d", n_pop, target);
        end
    endtask

    // Leaves the caller just after the edge that starts cycle 0 out of reset.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        gnt_en = 1'b1;
        lat = 1;
        exp_q.delete();
        #1;
        check("rst_if_valid", 32'(if_valid), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_imem_addr", imem_addr, RESET_PC_DEFAULT);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Memory model: answers each grant after lat cycles, strictly in order.
    always @(negedge clk) begin
        if (!rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rvalid = 1'b0;
            imem_gnt = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            imem_gnt = gnt_en;
            if (imem_req && gnt_en) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat);
                grant_cnt++;
                if (imem_addr == 32'h10) g10++;
            end
        end
    end

    // Scoreboard monitor: every accepted decode handshake must match the next expected PC.
    always @(negedge clk) begin
        if (rst && if_valid && if_ready && !redirect_valid) begin
            n_pop++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got pc %h, want no entry", if_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (if_pc !== mon_exp || if_instr !== mem_word(mon_exp)) begin
                    fails++;
                    $display("FAIL pop_entry: got pc %h instr %h, want pc %h instr %h",
                             if_pc, if_instr, mon_exp, mem_word(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with 1-cycle memory
        do_reset();
        expect_seq(32'h0, 64);
        @(negedge clk);
        check("s1_req_c0", 32'(imem_req), 1);
        check("s1_addr_c0", imem_addr, 32'h0);
        @(negedge clk);
        check("s1_addr_c1", imem_addr, 32'h4);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("s1_if_valid", 32'(if_valid), 1);
            check("s1_if_pc", if_pc, 32'(4 * k));
        end

        // Decode stall: head held, fetch stops on credit
        @(posedge clk); #1;
        if_ready = 1'b0;
        g0 = grant_cnt;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("s2_if_valid", 32'(if_valid), 1);
            check("s2_if_pc", if_pc, 32'h18);
        end
        check("s2_req_stalled", 32'(imem_req), 0);
        check("s2_grants", 32'((grant_cnt - g0) <= 2), 1);
        @(posedge clk); #1;
        if_ready = 1'b1;
        @(negedge clk);
        check("s2_resume_req", 32'(imem_req), 1);
        check("s2_resume_addr", imem_addr, 32'h20);
        wait_pops(n_pop + 6, 60);

        // Grant withheld: address held, no duplicate
        do_reset();
        expect_seq(32'h0, 64);
        g10 = 0;
        repeat (4) @(posedge clk);
        #1;
        gnt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s3_req_held", 32'(imem_req), 1);
            check("s3_addr_held", imem_addr, 32'h10);
        end
        @(posedge clk); #1;
        gnt_en = 1'b1;
        wait_pops(n_pop + 8, 60);
        check("s3_single_grant", 32'(g10), 1);

        // Redirect with two responses in flight
        do_reset();
        lat = 3;
        expect_seq(32'h0, 64);
        repeat (2) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        exp_q.delete();
        expect_seq(32'h100, 64);
        @(negedge clk);
        check("s4_req_during_redirect", 32'(imem_req), 0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("s4_if_valid_flushed", 32'(if_valid), 0);
        check("s4_addr_after", imem_addr, 32'h100);
        @(negedge clk);
        check("s4_first_req", 32'(imem_req), 1);
        check("s4_first_addr", imem_addr, 32'h100);
        wait_pops(n_pop + 4, 80);

        // Redirect coinciding with gnt and rvalid
        do_reset();
        expect_seq(32'h0, 64);
        repeat (5) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        exp_q.delete();
        expect_seq(32'h200, 64);
        @(negedge clk);
        check("s5_req_during_redirect", 32'(imem_req), 0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("s5_if_valid_flushed", 32'(if_valid), 0);
        check("s5_req_after", 32'(imem_req), 1);
        check("s5_addr_after", imem_addr, 32'h200);
        wait_pops(n_pop + 6, 60);

        // Back-to-back redirects: last wins, drops accumulate
        do_reset();
        lat = 3;
        expect_seq(32'h0, 64);
        repeat (2) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        exp_q.delete();
        @(posedge clk); #1;
        redirect_pc = 32'h83;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        expect_seq(32'h80, 64);
        @(negedge clk);
        check("s6_req", 32'(imem_req), 1);
        check("s6_addr", imem_addr, 32'h80);
        wait_pops(n_pop + 4, 80);

        // Reset pulse mid-stream
        do_reset();
        expect_seq(32'h0, 64);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("s7_valid_before_rst", 32'(if_valid), 1);
        do_reset();
        expect_seq(32'h0, 64);
        @(negedge clk);
        check("s7_req_after_rst", 32'(imem_req), 1);
        check("s7_addr_after_rst", imem_addr, RESET_PC_DEFAULT);
        wait_pops(n_pop + 6, 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
